mac_simd_acc: RTL and testbench

MAC_SIMD_ACC -- requirements
Module: mac_simd_acc

---
 rtl/mac_simd_acc_if.sv | 30 +++
 rtl/mac_simd_acc.sv | 211 +++++++++++++++++++++
 tb/tb_mac_simd_acc.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_simd_acc_if.sv
// Operand, configuration and result signals of the SIMD multiply-accumulate
// block, bundled so the block and its driver share one connection.
interface mac_simd_acc_if #(
  parameter int LANES = 2,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic                     cfg;
  logic                     cfg_mode;
  logic [CNT_W-1:0]         cfg_len;
  logic                     in_valid;
  logic                     in_ready;
  logic [8*LANES-1:0]       in_a;
  logic [8*LANES-1:0]       in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W*LANES-1:0]   acc_out;
  logic [LANES-1:0]         ovf;
  logic                     busy;

  modport master (
    output cfg, cfg_mode, cfg_len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, acc_out, ovf, busy
  );

  modport slave (
    input  cfg, cfg_mode, cfg_len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, acc_out, ovf, busy
  );
endinterface

// File: rtl/mac_simd_acc.sv
// SIMD multiply-accumulate: LANES x int8 or LANES/2 x int16 signed products
// summed into saturating per-lane accumulators over a configured number of
// beats. Three-stage datapath: operand register, product register, accumulate.
module mac_simd_acc #(
  parameter int LANES = 2,
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_simd_acc_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic                     mode_r;
  logic [CNT_W-1:0]         len_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         cnt_nx_s;
  logic                     drain_r;
  logic                     hs_s;
  logic                     start_s;
  logic                     last_s;
  logic [8*LANES-1:0]       op_a_r;
  logic [8*LANES-1:0]       op_b_r;
  logic                     op_vld_r;
  logic signed [31:0]       prod_s [LANES];
  logic signed [31:0]       prod_r [LANES];
  logic                     prod_vld_r;
  logic signed [ACC_W-1:0]  acc_r [LANES];
  logic [ACC_W:0]           sat_s [LANES];
  logic [LANES-1:0]         ovf_r;
  logic                     in_ready_r;
  logic                     out_valid_r;
  logic                     busy_r;
  logic [ACC_W*LANES-1:0]   acc_out_s;

  // Signed 8x8 product, sign-extended to the common 32-bit product width.
  function automatic logic signed [31:0] mul8(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
    logic signed [15:0] p;
    p = 16'(a) * 16'(b);
    return {{16{p[15]}}, p};
  endfunction

  // Signed 16x16 product.
  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Saturating add; MSB of the result flags that clipping occurred.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                             input logic signed [31:0] p);
    logic [ACC_W:0] sum;
    logic [ACC_W:0] res;
    sum = {acc[ACC_W-1], acc} + {{(ACC_W-31){p[31]}}, p};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      res = {1'b0, sum[ACC_W-1:0]};
    end
    return res;
  endfunction

  assign hs_s     = bus.in_valid & in_ready_r;
  assign start_s  = (state_r == IDLE) & bus.cfg;
  assign cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign last_s   = hs_s & (cnt_nx_s == len_r);

  // Next-state decode; a zero-length run skips straight to DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cfg) begin
          if (bus.cfg_len == {CNT_W{1'b0}}) state_s = DONE;
          else                              state_s = ACC;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (last_s) state_s = DRAIN;
        else        state_s = ACC;
      end
      DRAIN: begin
        if (drain_r) state_s = DONE;
        else         state_s = DRAIN;
      end
      DONE: begin
        if (bus.out_ready) state_s = IDLE;
        else               state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ACC);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // Run configuration, beat counter and the two-cycle drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r  <= 1'b0;
      len_r   <= {CNT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      drain_r <= 1'b0;
    end else begin
      if (start_s) begin
        mode_r <= bus.cfg_mode;
        len_r  <= bus.cfg_len;
        cnt_r  <= {CNT_W{1'b0}};
      end else if (hs_s) begin
        cnt_r  <= cnt_nx_s;
      end
      drain_r <= (state_r == DRAIN) ? ~drain_r : 1'b0;
    end
  end

  // Per-lane products from the registered operands in the latched mode.
  always_comb begin
    for (int i = 0; i < LANES; i++) prod_s[i] = 32'sd0;
    if (mode_r == 1'b0) begin
      for (int i = 0; i < LANES; i++)
        prod_s[i] = mul8(op_a_r[8*i +: 8], op_b_r[8*i +: 8]);
    end else begin
      for (int j = 0; j < LANES/2; j++)
        prod_s[2*j] = mul16(op_a_r[16*j +: 16], op_b_r[16*j +: 16]);
    end
  end

  // Operand and product pipeline stages; only handshaken beats carry valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r     <= {(8*LANES){1'b0}};
      op_b_r     <= {(8*LANES){1'b0}};
      op_vld_r   <= 1'b0;
      prod_vld_r <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_r[i] <= 32'sd0;
    end else begin
      op_vld_r   <= hs_s;
      prod_vld_r <= op_vld_r;
      if (hs_s) begin
        op_a_r <= bus.in_a;
        op_b_r <= bus.in_b;
      end
      if (op_vld_r) begin
        for (int i = 0; i < LANES; i++) prod_r[i] <= prod_s[i];
      end
    end
  end

  // Saturated sum of each accumulator with its pending product.
  always_comb begin
    for (int i = 0; i < LANES; i++) sat_s[i] = sat_add(acc_r[i], prod_r[i]);
  end

  // Accumulators and sticky overflow, cleared by an accepted cfg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) acc_r[i] <= {ACC_W{1'b0}};
    end else if (start_s) begin
      ovf_r <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) acc_r[i] <= {ACC_W{1'b0}};
    end else if (prod_vld_r) begin
      for (int i = 0; i < LANES; i++) begin
        acc_r[i] <= sat_s[i][ACC_W-1:0];
        ovf_r[i] <= ovf_r[i] | sat_s[i][ACC_W];
      end
    end
  end

  // Result bus is forced to zero unless a result is being presented.
  always_comb begin
    acc_out_s = {(ACC_W*LANES){1'b0}};
    for (int i = 0; i < LANES; i++)
      acc_out_s[ACC_W*i +: ACC_W] = out_valid_r ? acc_r[i] : {ACC_W{1'b0}};
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.ovf       = ovf_r;
  assign bus.acc_out   = acc_out_s;

endmodule

// File: tb/tb_mac_simd_acc.sv
// Scoreboard bench for mac_simd_acc: two instances (ACC_W=40 and ACC_W=33),
// directed operand beats, expected results queued at run start and popped by
// per-instance monitors on each result handshake.
module tb_mac_simd_acc;

  logic clk;
  logic rst_n;

  mac_simd_acc_if #(.LANES(2), .ACC_W(40), .CNT_W(8)) bus0 ();
  mac_simd_acc_if #(.LANES(2), .ACC_W(33), .CNT_W(8)) bus1 ();

  mac_simd_acc #(.LANES(2), .ACC_W(40), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  mac_simd_acc #(.LANES(2), .ACC_W(33), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [79:0] acc;
    logic [1:0]  ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [79:0] p40(input logic signed [39:0] l0, input logic signed [39:0] l1);
    return {l1, l0};
  endfunction

  // Result monitor for the 40-bit instance.
  always @(negedge clk) begin
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        chk("res0_unexpected", 80'd1, 80'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("res0_acc", bus0.acc_out, e.acc);
        chk("res0_ovf", {78'd0, bus0.ovf}, {78'd0, e.ovf});
      end
    end
  end

  // Result monitor for the 33-bit instance.
  always @(negedge clk) begin
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        chk("res1_unexpected", 80'd1, 80'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("res1_acc", {14'd0, bus1.acc_out}, e.acc);
        chk("res1_ovf", {78'd0, bus1.ovf}, {78'd0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [79:0] acc, input logic [1:0] ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    q0.push_back(e);
  endtask

  task automatic start0(input logic mode, input logic [7:0] len);
    bus0.cfg = 1'b1; bus0.cfg_mode = mode; bus0.cfg_len = len;
    tick();
    bus0.cfg = 1'b0;
  endtask

  task automatic beat0(input logic [15:0] a, input logic [15:0] b);
    bit hs = 1'b0;
    int n = 0;
    bus0.in_valid = 1'b1; bus0.in_a = a; bus0.in_b = b;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = bus0.in_ready;
      tick();
      n++;
    end
    bus0.in_valid = 1'b0;
    chk("beat0_hs", {79'd0, hs}, 80'd1);
  endtask

  task automatic wait_idle0();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.busy && n < 20);
    chk("idle0", {79'd0, bus0.busy}, 80'd0);
    tick();
  endtask

  task automatic start1(input logic mode, input logic [7:0] len);
    bus1.cfg = 1'b1; bus1.cfg_mode = mode; bus1.cfg_len = len;
    tick();
    bus1.cfg = 1'b0;
  endtask

  task automatic beat1(input logic [15:0] a, input logic [15:0] b);
    bit hs = 1'b0;
    int n = 0;
    bus1.in_valid = 1'b1; bus1.in_a = a; bus1.in_b = b;
    while (!hs && n < 20) begin
      @(negedge clk);
      hs = bus1.in_ready;
      tick();
      n++;
    end
    bus1.in_valid = 1'b0;
    chk("beat1_hs", {79'd0, hs}, 80'd1);
  endtask

  task automatic wait_idle1();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus1.busy && n < 20);
    chk("idle1", {79'd0, bus1.busy}, 80'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    int   n;
    rst_n = 1'b1;
    bus0.cfg = 1'b0; bus0.cfg_mode = 1'b0; bus0.cfg_len = 8'd0;
    bus0.in_valid = 1'b0; bus0.in_a = 16'h0000; bus0.in_b = 16'h0000;
    bus0.out_ready = 1'b1;
    bus1.cfg = 1'b0; bus1.cfg_mode = 1'b0; bus1.cfg_len = 8'd0;
    bus1.in_valid = 1'b0; bus1.in_a = 16'h0000; bus1.in_b = 16'h0000;
    bus1.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flags", {77'd0, bus0.in_ready, bus0.out_valid, bus0.busy}, 80'd0);
    chk("rst_acc", bus0.acc_out, 80'd0);
    chk("rst_ovf", {78'd0, bus0.ovf}, 80'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Beats offered while idle must be ignored.
    bus0.in_valid = 1'b1; bus0.in_a = 16'h7F7F; bus0.in_b = 16'h7F7F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_ready", {79'd0, bus0.in_ready}, 80'd0);
      tick();
    end
    bus0.in_valid = 1'b0;

    // mode0 len3: lane0 = 3*(2*4) = 24, lane1 = 3*(3*5) = 45.
    push0(p40(40'sd24, 40'sd45), 2'b00);
    start0(1'b0, 8'd3);
    chk("busy_acc", {79'd0, bus0.busy}, 80'd1);
    beat0(16'h0302, 16'h0504);
    beat0(16'h0302, 16'h0504);
    beat0(16'h0302, 16'h0504);
    @(negedge clk); chk("lat_k0", {79'd0, bus0.out_valid}, 80'd0);
    @(negedge clk); chk("lat_k1", {79'd0, bus0.out_valid}, 80'd0);
    @(negedge clk); chk("lat_k2", {79'd0, bus0.out_valid}, 80'd1);
    tick();
    wait_idle0();

    // mode0 len2 back to back: lane0 = 2*(-128*-128) = 32768, lane1 = 2*(-1*1) = -2.
    push0(p40(40'sd32768, -40'sd2), 2'b00);
    start0(1'b0, 8'd2);
    beat0(16'hFF80, 16'h0180);
    beat0(16'hFF80, 16'h0180);
    wait_idle0();

    // Same run with a three-cycle in_valid gap.
    push0(p40(40'sd32768, -40'sd2), 2'b00);
    start0(1'b0, 8'd2);
    beat0(16'hFF80, 16'h0180);
    tick(); tick(); tick();
    beat0(16'hFF80, 16'h0180);
    wait_idle0();

    // mode1 len1: -32768 * -32768 = 2^30 in lane0, lane1 zero.
    push0(p40(40'sh0040000000, 40'sd0), 2'b00);
    start0(1'b1, 8'd1);
    beat0(16'h8000, 16'h8000);
    wait_idle0();

    // Result held under back-pressure; cfg in DONE ignored.
    bus0.out_ready = 1'b0;
    push0(p40(40'sd8, 40'sd15), 2'b00);
    start0(1'b0, 8'd1);
    beat0(16'h0302, 16'h0504);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.out_valid && n < 20);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {79'd0, bus0.out_valid}, 80'd1);
      chk("hold_acc", bus0.acc_out, p40(40'sd8, 40'sd15));
      if (k == 1) begin
        bus0.cfg = 1'b1; bus0.cfg_mode = 1'b0; bus0.cfg_len = 8'd5;
      end else begin
        bus0.cfg = 1'b0;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_busy", {79'd0, bus0.busy}, 80'd0);
    chk("post_valid", {79'd0, bus0.out_valid}, 80'd0);
    chk("post_acc_zero", bus0.acc_out, 80'd0);
    tick();

    // Reset in the middle of a run discards the in-flight beat.
    start0(1'b0, 8'd3);
    beat0(16'h7F7F, 16'h7F7F);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {77'd0, bus0.in_ready, bus0.out_valid, bus0.busy}, 80'd0);
    chk("midrst_acc", bus0.acc_out, 80'd0);
    chk("midrst_ovf", {78'd0, bus0.ovf}, 80'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    push0(p40(40'sd1, 40'sd1), 2'b00);
    start0(1'b0, 8'd1);
    beat0(16'h0101, 16'h0101);
    wait_idle0();

    // Zero-length run gives an immediate all-zero result.
    push0(80'd0, 2'b00);
    start0(1'b0, 8'd0);
    wait_idle0();

    // ACC_W=33: four 2^30 products saturate lane0 at 2^32-1.
    e1.acc = {14'd0, 33'd0, 33'h0FFFFFFFF};
    e1.ovf = 2'b01;
    q1.push_back(e1);
    start1(1'b1, 8'd4);
    for (int k = 0; k < 4; k++) beat1(16'h8000, 16'h8000);
    wait_idle1();
    @(negedge clk);
    chk("ovf1_sticky", {78'd0, bus1.ovf}, {78'd0, 2'b01});
    tick();
    e1.acc = 80'd0;
    e1.ovf = 2'b00;
    q1.push_back(e1);
    start1(1'b0, 8'd0);
    wait_idle1();

    tick(); tick();
    chk("q0_empty", 80'(q0.size()), 80'd0);
    chk("q1_empty", 80'(q1.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
